// File: rtl/servo_pwm_ctrl_if.sv
// servo_pwm_ctrl_if: Avalon-MM register access bundle for the servo controller.
interface servo_pwm_ctrl_if;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    modport master(output address, write, writedata, read, input readdata);
    modport slave(input address, write, writedata, read, output readdata);
endinterface

// File: rtl/servo_pwm_ctrl.sv
// servo_pwm_ctrl: Avalon-MM servo PWM generator with frame-aligned slew limiting.
module servo_pwm_ctrl #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int PERIOD_US   = 20000,
    parameter int MIN_US      = 1000,
    parameter int MAX_US      = 2000,
    parameter int CENTER_US   = 1500
) (
    input  logic              clk,
    input  logic              reset,
    servo_pwm_ctrl_if.slave   bus,
    output logic              pwm_out,
    output logic              high_out,
    output logic              gnd_out
);
    localparam int DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [15:0] FRAME_MAX = 16'(PERIOD_US - 1);
    localparam logic [15:0] MIN_V = 16'(MIN_US);
    localparam logic [15:0] MAX_V = 16'(MAX_US);
    localparam logic [15:0] CENTER_V = 16'(CENTER_US);

    logic          enable_q, enable_d;
    logic [15:0]   target_q, target_d;
    logic [15:0]   step_q, step_d;
    logic [15:0]   cur_q, cur_d;
    logic [15:0]   us_cnt_q, us_cnt_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          pwm_q, pwm_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          us_tick, frame_start;
    logic [15:0]   wdata, clamped, diff, slewed;
    logic          unused_wdata_hi;

    assign unused_wdata_hi = ^bus.writedata[31:16];

    always_comb begin
        wdata = bus.writedata[15:0];
        clamped = wdata < MIN_V ? MIN_V : (wdata > MAX_V ? MAX_V : wdata);
        us_tick = enable_q && pre_q == PRE_MAX;
        frame_start = us_tick && us_cnt_q == FRAME_MAX;
        diff = target_q > cur_q ? target_q - cur_q : cur_q - target_q;
        // Snap to target when the remaining distance fits in one step, so no overshoot
        slewed = (step_q == 16'd0 || step_q >= diff) ? target_q
               : (target_q > cur_q ? cur_q + step_q : cur_q - step_q);
        enable_d = bus.write && bus.address == 2'd0 ? bus.writedata[0] : enable_q;
        target_d = bus.write && bus.address == 2'd1 ? clamped : target_q;
        step_d = bus.write && bus.address == 2'd2 ? wdata : step_q;
        pre_d = !enable_q || us_tick ? '0 : pre_q + 1'b1;
        us_cnt_d = !enable_q || frame_start ? 16'd0 : (us_tick ? us_cnt_q + 16'd1 : us_cnt_q);
        cur_d = !enable_q ? target_q : (frame_start ? slewed : cur_q);
        pwm_d = enable_q && us_cnt_q < cur_q;
        rdata_d = !bus.read ? 32'd0
                : bus.address == 2'd0 ? {31'd0, enable_q}
                : bus.address == 2'd1 ? {16'd0, target_q}
                : bus.address == 2'd2 ? {16'd0, step_q}
                : {14'd0, enable_q, cur_q != target_q, cur_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q <= 1'b0;
            target_q <= CENTER_V;
            step_q   <= 16'd0;
            cur_q    <= CENTER_V;
            us_cnt_q <= 16'd0;
            pre_q    <= '0;
            pwm_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            enable_q <= enable_d;
            target_q <= target_d;
            step_q   <= step_d;
            cur_q    <= cur_d;
            us_cnt_q <= us_cnt_d;
            pre_q    <= pre_d;
            pwm_q    <= pwm_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.readdata = rdata_q;
    assign pwm_out = pwm_q;
    assign high_out = 1'b1;
    assign gnd_out = 1'b0;
endmodule

// File: tb/tb_servo_pwm_ctrl.sv
// tb_servo_pwm_ctrl: scoreboard bench on a scaled timebase (DIV=2, 100 us frame, limits 20..80 us).
module tb_servo_pwm_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pwm_out, high_out, gnd_out;
    logic rv;
    int total = 0;
    int bad = 0;

    typedef struct {
        string       nm;
        logic [31:0] v;
    } exp_t;

    exp_t rd_q[$];
    int   pw_q[$];
    int   per_q[$];

    servo_pwm_ctrl_if bus();

    servo_pwm_ctrl #(
        .CLK_FREQ_HZ(2_000_000),
        .PERIOD_US(100),
        .MIN_US(20),
        .MAX_US(80),
        .CENTER_US(50)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave),
        .pwm_out(pwm_out),
        .high_out(high_out),
        .gnd_out(gnd_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) rv <= reset ? 1'b0 : bus.read;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Read-data monitor: one expected entry per read, compared when readdata is valid
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rv) begin
            if (rd_q.size() == 0) chk("rd_unexpected", bus.readdata, 32'hdead_beef);
            else begin
                e = rd_q.pop_front();
                chk(e.nm, bus.readdata, e.v);
            end
        end
    end

    // Pulse monitor: high width on each fall, rise-to-rise period on each rise
    initial begin
        int hcnt, cyc, last_rise;
        logic prev;
        hcnt = 0; cyc = 0; last_rise = -1; prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hcnt = 0; last_rise = -1; prev = 1'b0;
            end else begin
                cyc++;
                if (pwm_out && !prev) begin
                    if (last_rise >= 0 && per_q.size() > 0) chk("period", cyc - last_rise, per_q.pop_front());
                    last_rise = cyc;
                end
                if (pwm_out) hcnt++;
                else if (prev) begin
                    if (pw_q.size() > 0) chk("width", hcnt, pw_q.pop_front());
                    hcnt = 0;
                end
                prev = pwm_out;
            end
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address = a; bus.writedata = d; bus.write = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] ex, input string nm);
        exp_t e;
        e.nm = nm; e.v = ex;
        rd_q.push_back(e);
        @(negedge clk);
        bus.address = a; bus.read = 1'b1;
        @(negedge clk);
        bus.read = 1'b0;
    endtask

    task automatic wait_edge(input logic lvl, input string nm);
        logic p;
        int n;
        p = pwm_out; n = 0;
        @(negedge clk);
        while (!(p != lvl && pwm_out == lvl) && n < 1000) begin
            p = pwm_out;
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(p != lvl && pwm_out == lvl), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] st4 [5];
        int w4 [5];
        st4 = '{32'h30028, 32'h30032, 32'h3003C, 32'h30046, 32'h20050};
        w4 = '{80, 100, 120, 140, 160};
        bus.address = 2'd0; bus.write = 1'b0; bus.read = 1'b0; bus.writedata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_pwm", {31'd0, pwm_out}, 32'd0);
        chk("rst_high", {31'd0, high_out}, 32'd1);
        chk("rst_gnd", {31'd0, gnd_out}, 32'd0);
        chk("rst_rdata", bus.readdata, 32'd0);
        reset = 1'b0;
        rd(2'd3, 32'h32, "rst_status");
        rd(2'd0, 32'h0, "rst_ctrl");
        rd(2'd2, 32'h0, "rst_step");
        rd(2'd1, 32'h32, "rst_target");
        wr(2'd1, 32'd300);
        rd(2'd1, 32'd80, "clamp_hi");
        wr(2'd1, 32'd5);
        rd(2'd1, 32'd20, "clamp_lo");
        wr(2'd1, 32'd45);
        rd(2'd1, 32'd45, "tgt_mid");
        rd(2'd3, 32'd45, "dis_cur_follow");
        wr(2'd3, 32'hffff);
        rd(2'd3, 32'd45, "status_ro");
        // Fixed width: 24 us -> 48 clk high, 200 clk frame
        wr(2'd1, 32'd24);
        wr(2'd2, 32'd0);
        repeat (3) pw_q.push_back(48);
        repeat (2) per_q.push_back(200);
        wr(2'd0, 32'd1);
        repeat (3) wait_edge(1'b0, "t2_fall");
        rd(2'd3, 32'h20018, "t2_status");
        // Slew 30 -> 80 in steps of 10
        wr(2'd1, 32'd30);
        wait_edge(1'b0, "t4_sync");
        wr(2'd2, 32'd10);
        wr(2'd1, 32'd80);
        for (int i = 0; i < 5; i++) pw_q.push_back(w4[i]);
        for (int i = 0; i < 5; i++) begin
            wait_edge(1'b0, "t4_fall");
            rd(2'd3, st4[i], "t4_status");
        end
        // Disable mid-pulse, then re-enable
        wait_edge(1'b1, "t5_rise");
        repeat (10) @(negedge clk);
        wr(2'd0, 32'd0);
        @(negedge clk);
        chk("dis_low", {31'd0, pwm_out}, 32'd0);
        rd(2'd3, 32'h50, "dis_status");
        wr(2'd1, 32'd60);
        pw_q.push_back(120);
        wr(2'd0, 32'd1);
        @(negedge clk);
        chk("reen_rise", {31'd0, pwm_out}, 32'd1);
        repeat (20) @(negedge clk);
        wr(2'd0, 32'd1);
        wait_edge(1'b0, "t5_fall");
        // Async reset in the middle of a pulse
        wait_edge(1'b1, "t6_rise");
        repeat (70) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_pwm", {31'd0, pwm_out}, 32'd0);
        chk("rst_async_rd", bus.readdata, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rd(2'd3, 32'h32, "post_rst_status");
        rd(2'd0, 32'h0, "post_rst_ctrl");
        chk("post_rst_pwm", {31'd0, pwm_out}, 32'd0);
        repeat (3) @(negedge clk);
        chk("drain", 32'(rd_q.size() + pw_q.size() + per_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
